// File: rtl/m00_axi_read_arbiter_rr_pkg.sv
// Shared types and helpers for the M00 read-path round-robin arbiter.
// Also intended for reuse by the write-side arbiter.
package m00_axi_read_arbiter_rr_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StIssue
    } arb_state_t;

    // One extra bit so a full counter (== MAX_OUTST) is representable.
    function automatic int unsigned cnt_width(input int unsigned max_outst);
        return $clog2(max_outst) + 1;
    endfunction

endpackage

// File: rtl/m00_axi_read_arbiter_rr_if.sv
// Engine-side and slice-side AR/R signals of the shared M00 MID read path.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface m00_axi_read_arbiter_rr_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 512,
    parameter int unsigned ID_W    = 4
);
    logic [NUM_REQ-1:0]        req_arvalid;
    logic [NUM_REQ-1:0]        req_arready;
    logic [NUM_REQ*ADDR_W-1:0] req_araddr;
    logic [NUM_REQ*8-1:0]      req_arlen;
    logic [NUM_REQ-1:0]        req_rvalid;
    logic [NUM_REQ-1:0]        req_rready;
    logic [DATA_W-1:0]         req_rdata;
    logic                      req_rlast;

    logic                      m_arvalid;
    logic                      m_arready;
    logic [ADDR_W-1:0]         m_araddr;
    logic [7:0]                m_arlen;
    logic [ID_W-1:0]           m_arid;
    logic                      m_rvalid;
    logic                      m_rready;
    logic [DATA_W-1:0]         m_rdata;
    logic [ID_W-1:0]           m_rid;
    logic                      m_rlast;

    modport master (
        input  req_arvalid, req_araddr, req_arlen, req_rready,
        input  m_arready, m_rvalid, m_rdata, m_rid, m_rlast,
        output req_arready, req_rvalid, req_rdata, req_rlast,
        output m_arvalid, m_araddr, m_arlen, m_arid, m_rready
    );

    modport slave (
        output req_arvalid, req_araddr, req_arlen, req_rready,
        output m_arready, m_rvalid, m_rdata, m_rid, m_rlast,
        input  req_arready, req_rvalid, req_rdata, req_rlast,
        input  m_arvalid, m_araddr, m_arlen, m_arid, m_rready
    );

endinterface

// File: rtl/m00_axi_read_arbiter_rr_arbiter_onehot.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
module m00_axi_read_arbiter_rr_arbiter_onehot #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         eligible,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant_oh,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       grant_any
);
    localparam int unsigned IdxW = $clog2(NUM_REQ);

    logic [IdxW-1:0] idx;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = IdxW'((32'(ptr) + k) % NUM_REQ);
            if (!grant_any && eligible[idx]) begin
                grant_any     = 1'b1;
                grant_oh[idx] = 1'b1;
                grant_idx     = idx;
            end
        end
    end

endmodule

// File: rtl/m00_axi_read_arbiter_rr.sv
// Round-robin arbiter sharing the M00 MID AR/R path between NUM_REQ engine requesters,
// with ARID stamping, RID-based R routing and a per-requester outstanding-burst cap.
module m00_axi_read_arbiter_rr
    import m00_axi_read_arbiter_rr_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned DATA_W    = 512,
    parameter int unsigned ID_W      = 4,
    parameter int unsigned MAX_OUTST = 8
) (
    input  logic                      ap_clk,
    input  logic                      areset_n,
    m00_axi_read_arbiter_rr_if.master bus,
    output logic                      err_bad_rid
);
    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned CntW = cnt_width(MAX_OUTST);

    arb_state_t        state_q;
    logic              ar_valid_q;
    logic [ADDR_W-1:0] ar_addr_q;
    logic [7:0]        ar_len_q;
    logic [IdxW-1:0]   gnt_q;
    logic [IdxW-1:0]   ptr_q;
    logic [CntW-1:0]   cnt_q [NUM_REQ];
    logic              err_q;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant_oh;
    logic [IdxW-1:0]    grant_idx;
    logic               grant_any;
    logic [ADDR_W-1:0]  sel_addr;
    logic [7:0]         sel_len;
    logic [NUM_REQ-1:0] inc;
    logic [NUM_REQ-1:0] dec;
    logic [NUM_REQ-1:0] r_valid;
    logic               r_ready;
    logic               rid_bad;
    logic               r_fire_last;
    logic [DATA_W-1:0]  r_data;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            eligible[i] = bus.req_arvalid[i] && (cnt_q[i] < CntW'(MAX_OUTST));
        end
    end

    m00_axi_read_arbiter_rr_arbiter_onehot #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .eligible  (eligible),
        .ptr       (ptr_q),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                sel_addr = sel_addr | bus.req_araddr[i*ADDR_W +: ADDR_W];
                sel_len  = sel_len | bus.req_arlen[i*8 +: 8];
            end
        end
    end

    assign bus.req_arready = (state_q == StIdle) ? grant_oh : '0;
    assign bus.m_arvalid   = ar_valid_q;
    assign bus.m_araddr    = ar_addr_q;
    assign bus.m_arlen     = ar_len_q;
    assign bus.m_arid      = ID_W'(gnt_q);

    // Out-of-range RIDs are sunk here so a stray beat can never stall the slice.
    assign rid_bad = 32'(bus.m_rid) >= NUM_REQ;

    always_comb begin
        r_valid = '0;
        r_ready = rid_bad;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!rid_bad && (32'(bus.m_rid) == i)) begin
                r_valid[i] = bus.m_rvalid;
                r_ready    = bus.req_rready[i];
            end
        end
    end

    assign r_data         = bus.m_rdata;
    assign bus.req_rvalid = r_valid;
    assign bus.m_rready   = r_ready;
    assign bus.req_rdata  = r_data;
    assign bus.req_rlast  = bus.m_rlast;
    assign r_fire_last    = bus.m_rvalid && r_ready && bus.m_rlast && !rid_bad;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            inc[i] = (state_q == StIssue) && bus.m_arready && (gnt_q == IdxW'(i));
            dec[i] = r_fire_last && (32'(bus.m_rid) == i) && (cnt_q[i] != '0);
        end
    end

    always_ff @(posedge ap_clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q    <= StIdle;
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            gnt_q      <= '0;
            ptr_q      <= '0;
            err_q      <= 1'b0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (grant_any) begin
                        ar_valid_q <= 1'b1;
                        ar_addr_q  <= sel_addr;
                        ar_len_q   <= sel_len;
                        gnt_q      <= grant_idx;
                        state_q    <= StIssue;
                    end
                end
                StIssue: begin
                    if (bus.m_arready) begin
                        ar_valid_q <= 1'b0;
                        ptr_q      <= (gnt_q == IdxW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (inc[i] && !dec[i]) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end else if (dec[i] && !inc[i]) begin
                    cnt_q[i] <= cnt_q[i] - 1'b1;
                end
            end

            if (bus.m_rvalid && rid_bad) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_bad_rid = err_q;

endmodule

// File: tb/tb_m00_axi_read_arbiter_rr.sv
// Self-checking bench for m00_axi_read_arbiter_rr: R-routing vector table, directed
// arbitration sequences, and randomized traffic against a behavioural model.
module tb_m00_axi_read_arbiter_rr;
    localparam int NREQ = 4;
    localparam int MAXO = 8;

    logic clk;
    logic areset_n;
    logic err_bad_rid;

    m00_axi_read_arbiter_rr_if #(.NUM_REQ(4), .ADDR_W(64), .DATA_W(512), .ID_W(4)) bus ();

    m00_axi_read_arbiter_rr #(
        .NUM_REQ   (4),
        .ADDR_W    (64),
        .DATA_W    (512),
        .ID_W      (4),
        .MAX_OUTST (8)
    ) dut (
        .ap_clk      (clk),
        .areset_n    (areset_n),
        .bus         (bus),
        .err_bad_rid (err_bad_rid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: outstanding counts, rotating priority start, one pending AR.
    int          m_cnt [NREQ];
    int          m_ptr;
    int          m_gnt;
    bit          m_pending;
    bit          m_err;
    logic [63:0] m_addr;
    logic [7:0]  m_len;

    logic [3:0]  last_arready;
    logic        last_arvalid;
    logic [63:0] last_araddr;
    logic [7:0]  last_arlen;
    logic [3:0]  last_arid;
    logic        last_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
        m_ptr = 0; m_gnt = 0; m_pending = 0; m_err = 0; m_addr = '0; m_len = '0;
    endtask

    // Lowest rotational distance from the priority start wins.
    function automatic int model_pick();
        int best  = -1;
        int bestd = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_arvalid[i] && m_cnt[i] < MAXO) begin
                int d = (i - m_ptr + NREQ) % NREQ;
                if (d < bestd) begin bestd = d; best = i; end
            end
        end
        return best;
    endfunction

    task automatic drive_idle();
        bus.req_arvalid = '0; bus.req_araddr = '0; bus.req_arlen = '0; bus.req_rready = '0;
        bus.m_arready = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = '0; bus.m_rid = '0;
        bus.m_rlast = 1'b0;
    endtask

    task automatic step();
        int         best;
        int         rid;
        bit         bad;
        bit         dec;
        logic [3:0] exp_rv;
        logic       exp_rr;
        @(negedge clk);
        best = model_pick();
        chk("req_arready", 64'(bus.req_arready),
            (!m_pending && best >= 0) ? (64'd1 << best) : 64'd0);
        chk("m_arvalid", 64'(bus.m_arvalid), 64'(m_pending));
        if (m_pending) begin
            chk("m_araddr", bus.m_araddr, m_addr);
            chk("m_arlen", 64'(bus.m_arlen), 64'(m_len));
            chk("m_arid", 64'(bus.m_arid), 64'(m_gnt));
        end
        rid    = int'(bus.m_rid);
        bad    = rid >= NREQ;
        exp_rv = (!bad && bus.m_rvalid) ? 4'(1 << rid) : 4'd0;
        exp_rr = bad ? 1'b1 : bus.req_rready[rid];
        chk("req_rvalid", 64'(bus.req_rvalid), 64'(exp_rv));
        chk("m_rready", 64'(bus.m_rready), 64'(exp_rr));
        chk("req_rlast", 64'(bus.req_rlast), 64'(bus.m_rlast));
        chk("req_rdata", bus.req_rdata[63:0] ^ bus.req_rdata[511:448],
            bus.m_rdata[63:0] ^ bus.m_rdata[511:448]);
        chk("err_bad_rid", 64'(err_bad_rid), 64'(m_err));
        last_arready = bus.req_arready; last_arvalid = bus.m_arvalid;
        last_araddr  = bus.m_araddr;    last_arlen   = bus.m_arlen;
        last_arid    = bus.m_arid;      last_err     = err_bad_rid;

        dec = bus.m_rvalid && !bad && exp_rr && bus.m_rlast && (m_cnt[rid] > 0);
        if (bus.m_rvalid && bad) m_err = 1;
        if (!m_pending) begin
            if (best >= 0) begin
                m_pending = 1; m_gnt = best;
                m_addr = bus.req_araddr[best*64 +: 64];
                m_len  = bus.req_arlen[best*8 +: 8];
            end
        end else if (bus.m_arready) begin
            m_pending = 0; m_cnt[m_gnt]++; m_ptr = (m_gnt + 1) % NREQ;
        end
        if (dec) m_cnt[rid]--;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        drive_idle();
        areset_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        areset_n = 1'b1;
    endtask

    typedef struct {
        logic       rvalid;
        logic [3:0] rid;
        logic [3:0] rready;
        logic       rlast;
        logic [3:0] exp_rvalid;
        logic       exp_rready;
    } rvec_t;

    rvec_t tbl [8];

    initial begin
        int          gq [$];
        int          ngr;
        logic [63:0] h_addr;
        logic [7:0]  h_len;
        logic [3:0]  h_id;

        tbl[0] = '{1'b1, 4'd0,  4'b0001, 1'b0, 4'b0001, 1'b1};
        tbl[1] = '{1'b1, 4'd2,  4'b1011, 1'b1, 4'b0100, 1'b0};
        tbl[2] = '{1'b1, 4'd3,  4'b1000, 1'b0, 4'b1000, 1'b1};
        tbl[3] = '{1'b0, 4'd1,  4'b1111, 1'b1, 4'b0000, 1'b1};
        tbl[4] = '{1'b1, 4'd1,  4'b0000, 1'b1, 4'b0010, 1'b0};
        tbl[5] = '{1'b1, 4'd5,  4'b0000, 1'b1, 4'b0000, 1'b1};
        tbl[6] = '{1'b1, 4'd7,  4'b1111, 1'b0, 4'b0000, 1'b1};
        tbl[7] = '{1'b1, 4'd15, 4'b0000, 1'b0, 4'b0000, 1'b1};

        drive_idle();
        areset_n = 1'b0;
        model_reset();
        #12;
        chk("rst_m_arvalid", 64'(bus.m_arvalid), 64'd0);
        chk("rst_m_araddr", bus.m_araddr, 64'd0);
        chk("rst_m_arid", 64'(bus.m_arid), 64'd0);
        chk("rst_m_arlen", 64'(bus.m_arlen), 64'd0);
        chk("rst_req_arready", 64'(bus.req_arready), 64'd0);
        chk("rst_err", 64'(err_bad_rid), 64'd0);
        @(posedge clk);
        #1;
        areset_n = 1'b1;

        // Single request from requester 0.
        bus.req_arvalid = 4'b0001; bus.req_araddr[63:0] = 64'h1000; bus.req_arlen[7:0] = 8'd7;
        bus.m_arready = 1'b1;
        step();
        chk("t1_grant", 64'(last_arready), 64'b0001);
        bus.req_arvalid = '0;
        step();
        chk("t1_arvalid", 64'(last_arvalid), 64'd1);
        chk("t1_araddr", last_araddr, 64'h1000);
        chk("t1_arid", 64'(last_arid), 64'd0);
        chk("t1_arlen", 64'(last_arlen), 64'd7);

        // All four requesting continuously.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_araddr[i*64 +: 64] = 64'hA000 + 64'(i * 'h100);
            bus.req_arlen[i*8 +: 8]    = 8'(i + 3);
        end
        bus.req_arvalid = 4'b1111; bus.m_arready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            for (int i = 0; i < NREQ; i++) if (last_arready[i]) gq.push_back(i);
        end
        chk("t2_ngrants", 64'(gq.size()), 64'd5);
        for (int k = 0; k < 5 && k < gq.size(); k++) chk("t2_order", 64'(gq[k]), 64'(k % NREQ));

        // Slice stalls for five cycles while an AR is pending.
        bus.m_arready = 1'b0;
        step();
        chk("t3_grant", 64'(last_arready), 64'b0010);
        for (int c = 0; c < 5; c++) begin
            step();
            if (c == 0) begin h_addr = last_araddr; h_len = last_arlen; h_id = last_arid; end
            chk("t3_arvalid", 64'(last_arvalid), 64'd1);
            chk("t3_addr_stable", last_araddr, h_addr);
            chk("t3_len_stable", 64'(last_arlen), 64'(h_len));
            chk("t3_id_stable", 64'(last_arid), 64'(h_id));
            chk("t3_no_grant", 64'(last_arready), 64'd0);
        end
        chk("t3_held_addr", h_addr, 64'hA100);
        bus.m_arready = 1'b1; bus.req_arvalid = '0;
        step();

        // R routing vectors, including out-of-range RIDs.
        do_reset();
        bus.m_rdata = {16{32'h5A5A_0F0F}};
        for (int t = 0; t < 8; t++) begin
            bus.m_rvalid = tbl[t].rvalid; bus.m_rid = tbl[t].rid;
            bus.req_rready = tbl[t].rready; bus.m_rlast = tbl[t].rlast;
            #1;
            chk("tbl_rvalid", 64'(bus.req_rvalid), 64'(tbl[t].exp_rvalid));
            chk("tbl_rready", 64'(bus.m_rready), 64'(tbl[t].exp_rready));
            step();
        end
        bus.m_rvalid = 1'b0;
        step();
        step();
        chk("t6_err_sticky", 64'(last_err), 64'd1);

        // Requester 1 hits the outstanding cap, then one rlast frees a slot.
        bus.req_arvalid = 4'b0010; bus.m_arready = 1'b1; ngr = 0;
        for (int c = 0; c < 24; c++) begin
            step();
            if (last_arready[1]) ngr++;
        end
        chk("t4_capped", 64'(ngr), 64'd8);
        bus.m_rvalid = 1'b1; bus.m_rid = 4'd1; bus.m_rlast = 1'b1; bus.req_rready = 4'b0010;
        step();
        chk("t4_still_blocked", 64'(last_arready), 64'd0);
        bus.m_rvalid = 1'b0;
        step();
        chk("t4_regrant", 64'(last_arready), 64'b0010);

        // AR handshake for id 2 coincides with its rlast handshake at count 3.
        do_reset();
        bus.req_arvalid = 4'b0100; bus.m_arready = 1'b1; ngr = 0;
        for (int c = 0; c < 7; c++) begin
            step();
            if (last_arready[2]) ngr++;
        end
        chk("t5_pre_grants", 64'(ngr), 64'd4);
        bus.m_rvalid = 1'b1; bus.m_rid = 4'd2; bus.m_rlast = 1'b1; bus.req_rready = 4'b0100;
        step();
        chk("t5_coincident_ar", 64'(last_arvalid), 64'd1);
        bus.m_rvalid = 1'b0; ngr = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (last_arready[2]) ngr++;
        end
        chk("t5_post_grants", 64'(ngr), 64'd5);

        // Asynchronous reset with an AR pending and the error flag set.
        do_reset();
        bus.m_rvalid = 1'b1; bus.m_rid = 4'd5;
        step();
        bus.m_rvalid = 1'b0; bus.req_arvalid = 4'b0001; bus.m_arready = 1'b0;
        step();
        step();
        chk("t7_pending", 64'(last_arvalid), 64'd1);
        chk("t7_err_set", 64'(last_err), 64'd1);
        #2;
        areset_n = 1'b0;
        #1;
        chk("t7_async_arvalid", 64'(bus.m_arvalid), 64'd0);
        chk("t7_async_err", 64'(err_bad_rid), 64'd0);
        drive_idle();
        model_reset();
        areset_n = 1'b1;
        @(posedge clk);
        #1;
        step();

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bus.req_arvalid = 4'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                bus.req_araddr[i*64 +: 64] = {$urandom, $urandom};
                bus.req_arlen[i*8 +: 8]    = 8'($urandom);
            end
            bus.m_arready  = ($urandom_range(0, 2) != 0);
            bus.m_rvalid   = 1'($urandom);
            bus.m_rid      = ($urandom_range(0, 31) == 0) ? 4'($urandom_range(4, 15))
                                                          : 4'($urandom_range(0, 3));
            bus.m_rlast    = 1'($urandom);
            bus.req_rready = 4'($urandom);
            bus.m_rdata    = {16{$urandom}};
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
